keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 41 ++++
 rtl/keypad_scanner_if.sv | 20 ++
 rtl/keypad_digit_accumulator.sv | 64 ++++++
 rtl/keypad_scanner.sv | 161 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared FSM state type, key codes and the (row, col) -> key code map for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEB_PRESS,
    ST_HELD,
    ST_DEB_RELEASE
  } kp_state_e;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = KEY_A;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = KEY_B;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = KEY_C;
      4'd12:   code = KEY_STAR;
      4'd13:   code = 4'd0;
      4'd14:   code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side matrix lines plus the debounced key and operand outputs of the scanner.
interface keypad_scanner_if;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [2:0]  digit_count;
  logic [13:0] number;
  logic        number_valid;

  modport master (
    input  row_in,
    output col_out, key_valid, key_code, digit_count, number, number_valid
  );

  modport slave (
    output row_in,
    input  col_out, key_valid, key_code, digit_count, number, number_valid
  );
endinterface

// File: rtl/keypad_digit_accumulator.sv
// Builds a binary operand from accepted digit keys; '*' clears, '#' publishes.
// number/number_valid update on the edge where key_valid is high (one cycle after the key pulse).
module keypad_digit_accumulator
  import keypad_pkg::*;
#(
  parameter int MAX_DIGITS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid_i,
  input  logic [3:0]  key_code_i,
  output logic [2:0]  digit_count_o,
  output logic [13:0] number_o,
  output logic        number_valid_o
);

  logic [13:0] acc_q, acc_d;
  logic [13:0] number_q, number_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        nv_q, nv_d;

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    number_d = number_q;
    nv_d     = 1'b0;
    if (key_valid_i) begin
      if (key_code_i <= 4'd9) begin
        // Digits beyond the operand width are dropped silently.
        if (cnt_q < 3'(MAX_DIGITS)) begin
          acc_d = acc_q * 14'd10 + {10'd0, key_code_i};
          cnt_d = cnt_q + 3'd1;
        end
      end else if (key_code_i == KEY_STAR) begin
        acc_d = '0;
        cnt_d = '0;
      end else if (key_code_i == KEY_HASH) begin
        number_d = acc_q;
        nv_d     = 1'b1;
        acc_d    = '0;
        cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      number_q <= '0;
      nv_q     <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      number_q <= number_d;
      nv_q     <= nv_d;
    end
  end

  assign digit_count_o  = cnt_q;
  assign number_o       = number_q;
  assign number_valid_o = nv_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with per-scan debounce and decimal operand entry.
// key_valid pulses the cycle after the sample edge that completes the qualifying scan.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int MAX_DIGITS     = 3
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.master  kp
);

  localparam int TW = $clog2(SCAN_TICKS);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]    sync1_q, sync2_q;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    col_q, col_d;
  logic          sample, scan_done;
  logic          found_q;
  logic [3:0]    found_code_q;
  logic          col_hit;
  logic [3:0]    col_code;
  logic          scan_found;
  logic [3:0]    scan_code;
  kp_state_e     state_q;
  logic [3:0]    cand_q;
  logic [CW-1:0] cnt_q, cnt_inc;
  logic          deb_reached;
  logic          kv_q;
  logic [3:0]    kc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= kp.row_in;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    sample    = (tick_q == TW'(SCAN_TICKS - 1));
    scan_done = sample && (col_q == 2'd3);
    tick_d    = sample ? '0 : tick_q + TW'(1);
    col_d     = sample ? col_q + 2'd1 : col_q;
  end

  // Walk rows high-to-low so the lowest pressed row wins within a column.
  always_comb begin
    col_hit  = 1'b0;
    col_code = '0;
    for (int r = 3; r >= 0; r--) begin
      if (!sync2_q[r]) begin
        col_hit  = 1'b1;
        col_code = key_map(2'(r), col_q);
      end
    end
  end

  assign scan_found = found_q | col_hit;
  assign scan_code  = found_q ? found_code_q : col_code;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q       <= '0;
      col_q        <= '0;
      found_q      <= 1'b0;
      found_code_q <= '0;
    end else begin
      tick_q <= tick_d;
      col_q  <= col_d;
      if (sample) begin
        found_q      <= (col_q == 2'd3) ? 1'b0 : scan_found;
        found_code_q <= scan_code;
      end
    end
  end

  assign cnt_inc     = cnt_q + CW'(1);
  assign deb_reached = (cnt_inc == CW'(DEBOUNCE_SCANS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      kv_q    <= 1'b0;
      kc_q    <= '0;
    end else begin
      kv_q <= 1'b0;
      if (scan_done) begin
        case (state_q)
          ST_IDLE: begin
            if (scan_found) begin
              cand_q <= scan_code;
              cnt_q  <= CW'(1);
              if (DEBOUNCE_SCANS == 1) begin
                kv_q    <= 1'b1;
                kc_q    <= scan_code;
                state_q <= ST_HELD;
              end else begin
                state_q <= ST_DEB_PRESS;
              end
            end
          end
          ST_DEB_PRESS: begin
            if (!scan_found) begin
              state_q <= ST_IDLE;
            end else if (scan_code != cand_q) begin
              cand_q <= scan_code;
              cnt_q  <= CW'(1);
            end else if (deb_reached) begin
              kv_q    <= 1'b1;
              kc_q    <= cand_q;
              state_q <= ST_HELD;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          ST_HELD: begin
            if (!scan_found) begin
              cnt_q   <= CW'(1);
              state_q <= (DEBOUNCE_SCANS == 1) ? ST_IDLE : ST_DEB_RELEASE;
            end
          end
          ST_DEB_RELEASE: begin
            if (scan_found) begin
              state_q <= ST_HELD;
            end else if (deb_reached) begin
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign kp.col_out   = ~(4'b0001 << col_q);
  assign kp.key_valid = kv_q;
  assign kp.key_code  = kc_q;

  keypad_digit_accumulator #(
    .MAX_DIGITS (MAX_DIGITS)
  ) u_acc (
    .clk            (clk),
    .reset          (reset),
    .key_valid_i    (kv_q),
    .key_code_i     (kc_q),
    .digit_count_o  (kp.digit_count),
    .number_o       (kp.number),
    .number_valid_o (kp.number_valid)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a column-gated keypad model (SCAN_TICKS=8, DEBOUNCE_SCANS=2).
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_TICKS     (8),
    .DEBOUNCE_SCANS (2),
    .MAX_DIGITS     (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif.master)
  );

  // held bit r*4+c: the key at row r, column c is pressed
  logic [15:0] held = '0;
  logic [3:0]  rows;
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      rows[r] = ~|(held[r*4 +: 4] & ~kif.col_out);
  end
  assign kif.row_in = rows;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int kv_cnt = 0;
  int nv_cnt = 0;
  int kv_cyc = 0;
  int nv_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (kif.key_valid === 1'b1) begin
      kv_cnt = kv_cnt + 1;
      kv_cyc = cyc;
    end
    if (kif.number_valid === 1'b1) begin
      nv_cnt = nv_cnt + 1;
      nv_cyc = cyc;
    end
  end

  function automatic int pos(input int code);
    case (code)
      1: return 0;   2: return 1;   3: return 2;   10: return 3;
      4: return 4;   5: return 5;   6: return 6;   11: return 7;
      7: return 8;   8: return 9;   9: return 10;  12: return 11;
      14: return 12; 0: return 13;  15: return 14; default: return 15;
    endcase
  endfunction

  // Returns #1 after the edge on which column 0 is driven again (a scan boundary).
  task automatic next_scan();
    int n = 0;
    while (kif.col_out == 4'b1110 && n < 40) begin @(posedge clk); #1; n++; end
    while (kif.col_out != 4'b1110 && n < 80) begin @(posedge clk); #1; n++; end
    total++;
    if (kif.col_out !== 4'b1110) begin
      bad++;
      $display("FAIL scan_wait got col_out=%b want 1110 within 80 cycles", kif.col_out);
    end
  endtask

  task automatic press_key(input int code);
    held = 16'd1 << pos(code);
    next_scan();
    next_scan();
    held = '0;
    next_scan();
    next_scan();
  endtask

  task automatic test_reset();
    logic [3:0] exp_col [4];
    exp_col = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    reset = 1'b1;
    held = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (kif.col_out !== 4'b1110) begin bad++; $display("FAIL rst_col got=%b want=1110", kif.col_out); end
    total++; if (kif.key_valid !== 1'b0) begin bad++; $display("FAIL rst_kv got=%b want=0", kif.key_valid); end
    total++; if (kif.key_code !== 4'd0) begin bad++; $display("FAIL rst_code got=%0d want=0", kif.key_code); end
    total++; if (kif.digit_count !== 3'd0) begin bad++; $display("FAIL rst_dc got=%0d want=0", kif.digit_count); end
    total++; if (kif.number !== 14'd0) begin bad++; $display("FAIL rst_num got=%0d want=0", kif.number); end
    total++; if (kif.number_valid !== 1'b0) begin bad++; $display("FAIL rst_nv got=%b want=0", kif.number_valid); end
    reset = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    total++; if (kif.col_out !== 4'b1110) begin bad++; $display("FAIL col_hold got=%b want=1110", kif.col_out); end
    @(posedge clk);
    #1;
    total++; if (kif.col_out !== exp_col[0]) begin bad++; $display("FAIL col_rot0 got=%b want=%b", kif.col_out, exp_col[0]); end
    for (int i = 1; i < 4; i++) begin
      repeat (8) @(posedge clk);
      #1;
      total++; if (kif.col_out !== exp_col[i]) begin bad++; $display("FAIL col_rot%0d got=%b want=%b", i, kif.col_out, exp_col[i]); end
    end
  endtask

  task automatic test_single_press();
    int k0 = kv_cnt;
    held = 16'd1 << pos(5);
    next_scan();
    total++; if (kv_cnt !== k0) begin bad++; $display("FAIL t2_early got=%0d pulses want=0", kv_cnt - k0); end
    next_scan();
    total++; if (kif.key_valid !== 1'b1) begin bad++; $display("FAIL t2_kv got=%b want=1", kif.key_valid); end
    total++; if (kif.key_code !== 4'd5) begin bad++; $display("FAIL t2_code got=%0d want=5", kif.key_code); end
    @(posedge clk);
    #1;
    total++; if (kif.key_valid !== 1'b0) begin bad++; $display("FAIL t2_kv_width got=%b want=0", kif.key_valid); end
    total++; if (kif.digit_count !== 3'd1) begin bad++; $display("FAIL t2_dc got=%0d want=1", kif.digit_count); end
    repeat (3) next_scan();
    total++; if (kv_cnt !== k0 + 1) begin bad++; $display("FAIL t2_held_pulses got=%0d want=1", kv_cnt - k0); end
    held = '0;
    next_scan();
    next_scan();
    total++; if (kv_cnt !== k0 + 1) begin bad++; $display("FAIL t2_release_pulses got=%0d want=1", kv_cnt - k0); end
  endtask

  task automatic test_number_entry();
    int n0;
    press_key(14);
    total++; if (kif.digit_count !== 3'd0) begin bad++; $display("FAIL t3_star_dc got=%0d want=0", kif.digit_count); end
    press_key(1);
    press_key(2);
    press_key(3);
    total++; if (kif.digit_count !== 3'd3) begin bad++; $display("FAIL t3_dc3 got=%0d want=3", kif.digit_count); end
    n0 = nv_cnt;
    press_key(15);
    total++; if (kif.number !== 14'd123) begin bad++; $display("FAIL t3_num got=%0d want=123", kif.number); end
    total++; if (nv_cnt !== n0 + 1) begin bad++; $display("FAIL t3_nv_pulses got=%0d want=1", nv_cnt - n0); end
    total++; if (nv_cyc !== kv_cyc + 1) begin bad++; $display("FAIL t3_nv_lag got=%0d want=1", nv_cyc - kv_cyc); end
    total++; if (kif.digit_count !== 3'd0) begin bad++; $display("FAIL t3_dc_clear got=%0d want=0", kif.digit_count); end
  endtask

  task automatic test_bounce();
    int k0 = kv_cnt;
    held = 16'd1 << pos(7);
    next_scan();
    held = '0;
    next_scan();
    next_scan();
    total++; if (kv_cnt !== k0) begin bad++; $display("FAIL t4_short got=%0d pulses want=0", kv_cnt - k0); end
    for (int i = 0; i < 4; i++) begin
      held = (i % 2 == 0) ? (16'd1 << pos(7)) : (16'd1 << pos(8));
      next_scan();
    end
    held = '0;
    next_scan();
    next_scan();
    total++; if (kv_cnt !== k0) begin bad++; $display("FAIL t4_alternate got=%0d pulses want=0", kv_cnt - k0); end
  endtask

  task automatic test_digit_limit();
    int k0 = kv_cnt;
    int n0;
    press_key(9);
    press_key(8);
    press_key(7);
    press_key(6);
    total++; if (kv_cnt !== k0 + 4) begin bad++; $display("FAIL t5_kv4 got=%0d want=4", kv_cnt - k0); end
    total++; if (kif.key_code !== 4'd6) begin bad++; $display("FAIL t5_code6 got=%0d want=6", kif.key_code); end
    total++; if (kif.digit_count !== 3'd3) begin bad++; $display("FAIL t5_dc_sat got=%0d want=3", kif.digit_count); end
    press_key(15);
    total++; if (kif.number !== 14'd987) begin bad++; $display("FAIL t5_num987 got=%0d want=987", kif.number); end
    press_key(4);
    press_key(2);
    press_key(14);
    n0 = nv_cnt;
    press_key(15);
    total++; if (kif.number !== 14'd0) begin bad++; $display("FAIL t5_num0 got=%0d want=0", kif.number); end
    total++; if (nv_cnt !== n0 + 1) begin bad++; $display("FAIL t5_nv0 got=%0d want=1", nv_cnt - n0); end
  endtask

  task automatic test_multi_and_reset();
    int k0;
    held = (16'd1 << pos(1)) | (16'd1 << pos(9));
    next_scan();
    next_scan();
    total++; if (kif.key_valid !== 1'b1) begin bad++; $display("FAIL t6_multi_kv got=%b want=1", kif.key_valid); end
    total++; if (kif.key_code !== 4'd1) begin bad++; $display("FAIL t6_multi_code got=%0d want=1", kif.key_code); end
    held = '0;
    next_scan();
    next_scan();
    held = 16'd1 << pos(3);
    next_scan();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (kif.col_out !== 4'b1110) begin bad++; $display("FAIL t6_rst_col got=%b want=1110", kif.col_out); end
    total++; if (kif.key_code !== 4'd0) begin bad++; $display("FAIL t6_rst_code got=%0d want=0", kif.key_code); end
    total++; if (kif.digit_count !== 3'd0) begin bad++; $display("FAIL t6_rst_dc got=%0d want=0", kif.digit_count); end
    total++; if (kif.number !== 14'd0) begin bad++; $display("FAIL t6_rst_num got=%0d want=0", kif.number); end
    reset = 1'b0;
    k0 = kv_cnt;
    next_scan();
    total++; if (kv_cnt !== k0) begin bad++; $display("FAIL t6_rearm_early got=%0d pulses want=0", kv_cnt - k0); end
    next_scan();
    total++; if (kif.key_valid !== 1'b1) begin bad++; $display("FAIL t6_rearm_kv got=%b want=1", kif.key_valid); end
    total++; if (kif.key_code !== 4'd3) begin bad++; $display("FAIL t6_rearm_code got=%0d want=3", kif.key_code); end
    held = '0;
    next_scan();
    next_scan();
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_number_entry();
    test_bounce();
    test_digit_limit();
    test_multi_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=time %0t want=finish earlier", $time);
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
